// File: rtl/register_file_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard_pkg                                         |
// | Shared MIPS register-file defaults and the hardwired-zero index.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package register_file_scoreboard_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_CNT_WIDTH  = 2;
  localparam int REG_ZERO       = 0;
endpackage
`default_nettype wire

// File: rtl/register_file_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard_if                                          |
// | Decode/writeback bus of the register file with its scoreboard.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface register_file_scoreboard_if
  import register_file_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS
) ();
  logic                             register_write;
  logic [ADDR_WIDTH-1:0]            write_register;
  logic [DATA_WIDTH-1:0]            write_data;
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [READ_PORTS-1:0]            read_busy;
  logic                             reserve_valid;
  logic [ADDR_WIDTH-1:0]            reserve_register;
  logic                             reserve_ready;
  logic                             flush;
  logic                             write_error;

  modport master (
    output register_write, write_register, write_data, read_register,
    output reserve_valid, reserve_register, flush,
    input  read_data, read_busy, reserve_ready, write_error
  );

  modport slave (
    input  register_write, write_register, write_data, read_register,
    input  reserve_valid, reserve_register, flush,
    output read_data, read_busy, reserve_ready, write_error
  );
endinterface
`default_nettype wire

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_scoreboard                                                       |
// | Pending-write counters per register: reservation, busy, write error. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             register_write,
  input  logic [ADDR_WIDTH-1:0]            write_register,
  input  logic                             reserve_valid,
  input  logic [ADDR_WIDTH-1:0]            reserve_register,
  input  logic                             flush,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register,
  output logic [READ_PORTS-1:0]            read_busy,
  output logic                             reserve_ready,
  output logic                             write_error
);
  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  cnt_q [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_d [DEPTH];
  logic                  write_error_q;
  logic                  wr_en;
  logic                  release_w;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] ridx;
  logic [CNT_WIDTH-1:0]  rcnt;

  assign wr_en         = register_write && (write_register != ZERO_IDX);
  assign release_w     = wr_en && (cnt_q[write_register] != '0);
  // A retiring write to the same register frees a slot in this very cycle.
  assign reserve_ready = (cnt_q[reserve_register] != CNT_MAX) ||
                         (release_w && (write_register == reserve_register));
  assign accept        = reserve_valid && reserve_ready && (reserve_register != ZERO_IDX);
  assign write_error   = write_error_q;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (accept && (reserve_register == ADDR_WIDTH'(r)) &&
                   !(release_w && (write_register == ADDR_WIDTH'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (release_w && (write_register == ADDR_WIDTH'(r)) &&
                   !(accept && (reserve_register == ADDR_WIDTH'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_comb begin
    read_busy = '0;
    ridx      = '0;
    rcnt      = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      ridx = read_register[i*ADDR_WIDTH +: ADDR_WIDTH];
      rcnt = cnt_q[ridx];
      if (BYPASS != 0) begin
        read_busy[i] = (rcnt > CNT_ONE) ||
                       ((rcnt == CNT_ONE) && !(release_w && (write_register == ridx)));
      end else begin
        read_busy[i] = (rcnt != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= '0;
      end
      write_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      write_error_q <= wr_en && (cnt_q[write_register] == '0) && !flush;
    end
  end
endmodule
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard                                             |
// | MIPS register file: N read ports, WB write bypass, RAW scoreboard.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int BYPASS     = 1,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  register_file_scoreboard_if.slave rf
);
  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0]            regs_q [DEPTH];
  logic                             wr_en;
  logic [ADDR_WIDTH-1:0]            ridx;
  logic [READ_PORTS*DATA_WIDTH-1:0] rdata;

  assign wr_en = rf.register_write && (rf.write_register != ZERO_IDX);

  // r0 is never written, so its reset value keeps it reading zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rf.write_register] <= rf.write_data;
    end
  end

  always_comb begin
    rdata = '0;
    ridx  = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      ridx = rf.read_register[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((BYPASS != 0) && wr_en && (rf.write_register == ridx)) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf.write_data;
      end else begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ridx];
      end
    end
  end

  assign rf.read_data = rdata;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_PORTS (READ_PORTS),
    .CNT_WIDTH  (CNT_WIDTH),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk              (clk),
    .reset_n          (reset_n),
    .register_write   (rf.register_write),
    .write_register   (rf.write_register),
    .reserve_valid    (rf.reserve_valid),
    .reserve_register (rf.reserve_register),
    .flush            (rf.flush),
    .read_register    (rf.read_register),
    .read_busy        (rf.read_busy),
    .reserve_ready    (rf.reserve_ready),
    .write_error      (rf.write_error)
  );
endmodule
`default_nettype wire
